quadratic_root_calc: RTL and testbench
======================================

Name: quadratic_root_calc

Overview:
- Final stage of the quadratic-equation datapath. Sits directly downstream of the combinational square-root lookup.
- Takes coefficients a and b, the discriminant delta, and its looked-up floor square root s.
- Classifies the root case, then computes x1 = (-b + s)/(2a) and x2 = (-b - s)/(2a) with one shared iterative restoring divider, behind a valid/ready handshake.
- Results are integer quotients truncated toward zero.

Parameters:
- W_COEF, 8, width of signed coefficients a and b.
- W_ROOT, 9, width of signed numerators, denominator, quotients, and the divider iteration count.
- DELTA_MAX, 324, largest delta the upstream square-root lookup covers; delta above this is out of range.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block idle and able to capture.
- a  in  W_COEF  signed coefficient a.
- b  in  W_COEF  signed coefficient b.
- delta  in  16  signed discriminant b*b - 4ac.
- sqrt_delta  in  8  unsigned floor square root of delta, from the lookup.
- out_valid  out  1  results valid; held until accepted.
- out_ready  in  1  consumer accepts results.
- x1  out  W_ROOT  signed root (-b+s)/(2a).
- x2  out  W_ROOT  signed root (-b-s)/(2a).
- root_status  out  2  0 = two distinct real roots, 1 = double root, 2 = no real roots, 3 = invalid.

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE; in_ready=1, out_valid=0, x1=x2=0, root_status=0; all internal registers cleared. An operation in flight is abandoned with no output.
- States: IDLE, CHECK, DIV1, DIV2, DONE.
- in_ready = (state == IDLE). It is a combinational decode of the state register.
- Capture: on an edge where in_valid && in_ready, register a, b, delta and sqrt_delta, then go to CHECK. In any other state in_valid is ignored.
- CHECK (1 cycle), classification in priority order:
  - a == 0, or delta > DELTA_MAX: status 3.
  - delta < 0: status 2.
  - delta == 0: status 1.
  - otherwise: status 0.
- CHECK exit for status 2 or 3: x1 = x2 = 0, go to DONE.
- CHECK exit for status 0 or 1: form n1 = -b + s, n2 = -b - s and d = 2a, all sign-extended to W_ROOT.
  - Ranges: |n| ≤ 146, d ∈ [-256, 254]; no overflow is possible.
  - Load the divider with |n1| and |d|, then go to DIV1.
- DIV1 and DIV2 each take exactly W_ROOT cycles of restoring division on magnitudes, one quotient bit per cycle, MSB first.
  - Quotient sign = sign(n) XOR sign(d); a zero quotient is never negative. The remainder is discarded.
  - At the end of DIV1, write x1 and reload the divider with |n2|. At the end of DIV2, write x2 and go to DONE.
- Latency, counting capture as edge 0:
  - Status 0/1: out_valid rises after edge 19 (1 + 9 + 9 with W_ROOT = 9).
  - Status 2/3: out_valid rises after edge 1.
- DONE: out_valid=1. x1, x2 and root_status are held stable until out_ready=1 is sampled, then the block returns to IDLE on that edge.
  - in_ready rises the following cycle; there is no same-cycle output/input overlap.
  - out_ready while not in DONE has no effect.
- x1, x2 and root_status retain their last values after DONE until the next result overwrites them.
- With delta == 0: s = 0, so x1 == x2.
- With a < 0 the roots swap order numerically; no sorting is performed.

Test Plan:
- a=1, b=-5, delta=1, s=1 -> after 19 cycles: x1=3, x2=2, status 0; out_valid held while out_ready=0 for 5 cycles, outputs stable throughout.
- a=1, b=2, delta=0, s=0 -> x1=-1, x2=-1, status 1. a=-1, b=0, delta=16, s=4 -> x1=-2, x2=2, status 0.
- Truncation: a=2, b=-1, delta=25, s=5 -> x1=1, x2=-1. Extremes: a=-128, b=-128, delta=16384 -> status 3 after 1 cycle.
- delta=-7 -> status 2, x1=x2=0, out_valid after edge 1. a=0, b=3, delta=9 -> status 3.
- Busy and handshake behaviour:
  - Toggle in_valid with new operands during DIV1 -> ignored; the original result is produced and in_ready stays 0.
  - Back-to-back jobs with out_ready tied high -> in_ready reasserts the cycle after DONE.
- Assert rst_n=0 mid-DIV2 -> outputs zero immediately, in_ready=1; a fresh job afterwards produces correct results.

Source files
------------

// File: rtl/quadratic_root_calc_if.sv
// quadratic_root_calc_if: operand/result handshake bundle for the quadratic root stage.
interface quadratic_root_calc_if #(
  parameter int W_COEF = 8,
  parameter int W_ROOT = 9
);
  logic in_valid;
  logic in_ready;
  logic signed [W_COEF-1:0] a;
  logic signed [W_COEF-1:0] b;
  logic signed [15:0] delta;
  logic [7:0] sqrt_delta;
  logic out_valid;
  logic out_ready;
  logic signed [W_ROOT-1:0] x1;
  logic signed [W_ROOT-1:0] x2;
  logic [1:0] root_status;
  modport master (
    output in_valid, a, b, delta, sqrt_delta, out_ready,
    input  in_ready, out_valid, x1, x2, root_status
  );
  modport slave (
    input  in_valid, a, b, delta, sqrt_delta, out_ready,
    output in_ready, out_valid, x1, x2, root_status
  );
endinterface

// File: rtl/quadratic_root_calc.sv
// quadratic_root_calc: classifies the root case and divides out x1, x2 with one shared restoring divider.
module quadratic_root_calc #(
  parameter int W_COEF    = 8,
  parameter int W_ROOT    = 9,
  parameter int DELTA_MAX = 324
) (
  input logic clk,
  input logic rst_n,
  quadratic_root_calc_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_DIV1  = 3'd2;
  localparam logic [2:0] S_DIV2  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic signed [15:0] D_MAX = DELTA_MAX[15:0];
  localparam logic [W_ROOT-1:0] LAST = W_ROOT'(W_ROOT - 1);
  logic [2:0] state;
  logic signed [W_COEF-1:0] a_r, b_r;
  logic signed [15:0] delta_r;
  logic [7:0] s_r;
  logic [1:0] status, st_r;
  logic signed [W_ROOT-1:0] a_x, b_x, s_x, n1, n2, d, q_signed;
  logic [W_ROOT-1:0] dvd, dvs, rem, cnt, n2_mag, q_next, rem_next;
  logic [W_ROOT:0] rem_sh;
  logic n1_neg, n2_neg, d_neg, fits, q_neg;
  logic signed [W_ROOT-1:0] x1_r, x2_r;
  logic [1:0] rs_r;
  function automatic logic [W_ROOT-1:0] mag(input logic signed [W_ROOT-1:0] v);
    return v[W_ROOT-1] ? -v : v;
  endfunction
  assign bus.in_ready    = state == S_IDLE;
  assign bus.out_valid   = state == S_DONE;
  assign bus.x1          = x1_r;
  assign bus.x2          = x2_r;
  assign bus.root_status = rs_r;
  assign a_x = {{(W_ROOT-W_COEF){a_r[W_COEF-1]}}, a_r};
  assign b_x = {{(W_ROOT-W_COEF){b_r[W_COEF-1]}}, b_r};
  assign s_x = W_ROOT'(s_r);
  assign n1  = s_x - b_x;
  assign n2  = -b_x - s_x;
  assign d   = a_x + a_x;
  assign status = (a_r == '0 || delta_r > D_MAX) ? 2'd3 :
                  delta_r < 0                     ? 2'd2 :
                  delta_r == 0                    ? 2'd1 : 2'd0;
  // One restoring step: shift the next dividend bit into the partial remainder.
  assign rem_sh   = {rem, dvd[W_ROOT-1]};
  assign fits     = rem_sh >= {1'b0, dvs};
  assign rem_next = fits ? W_ROOT'(rem_sh - {1'b0, dvs}) : rem_sh[W_ROOT-1:0];
  assign q_next   = {dvd[W_ROOT-2:0], fits};
  assign q_neg    = ((state == S_DIV1) ? n1_neg : n2_neg) ^ d_neg;
  assign q_signed = q_neg ? -q_next : q_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      delta_r <= '0;
      s_r     <= '0;
      st_r    <= '0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      cnt     <= '0;
      n2_mag  <= '0;
      n1_neg  <= 1'b0;
      n2_neg  <= 1'b0;
      d_neg   <= 1'b0;
      x1_r    <= '0;
      x2_r    <= '0;
      rs_r    <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          a_r     <= bus.a;
          b_r     <= bus.b;
          delta_r <= bus.delta;
          s_r     <= bus.sqrt_delta;
          state   <= S_CHECK;
        end
        S_CHECK: if (status[1]) begin
          rs_r  <= status;
          x1_r  <= '0;
          x2_r  <= '0;
          state <= S_DONE;
        end else begin
          st_r   <= status;
          dvd    <= mag(n1);
          dvs    <= mag(d);
          n2_mag <= mag(n2);
          n1_neg <= n1[W_ROOT-1];
          n2_neg <= n2[W_ROOT-1];
          d_neg  <= d[W_ROOT-1];
          rem    <= '0;
          cnt    <= '0;
          state  <= S_DIV1;
        end
        S_DIV1, S_DIV2: if (cnt == LAST) begin
          cnt <= '0;
          rem <= '0;
          if (state == S_DIV1) begin
            x1_r  <= q_signed;
            dvd   <= n2_mag;
            state <= S_DIV2;
          end else begin
            x2_r  <= q_signed;
            rs_r  <= st_r;
            dvd   <= q_next;
            state <= S_DONE;
          end
        end else begin
          dvd <= q_next;
          rem <= rem_next;
          cnt <= cnt + 1'b1;
        end
        S_DONE: if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_quadratic_root_calc.sv
// tb_quadratic_root_calc: directed jobs checked against literals and an arithmetic reference model.
module tb_quadratic_root_calc;
  typedef struct {int x1; int x2; int st;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  bit tie = 1'b0;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  quadratic_root_calc_if #(.W_COEF(8), .W_ROOT(9)) bus ();
  quadratic_root_calc #(.W_COEF(8), .W_ROOT(9), .DELTA_MAX(324)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  function automatic exp_t model(input int a, input int b, input int dl, input int s);
    exp_t e;
    e.st = (a == 0 || dl > 324) ? 3 : (dl < 0) ? 2 : (dl == 0) ? 1 : 0;
    e.x1 = (e.st >= 2) ? 0 : (s - b) / (2 * a);
    e.x2 = (e.st >= 2) ? 0 : (-b - s) / (2 * a);
    return e;
  endfunction
  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  always @(posedge clk) if (rst_n) begin
    if (bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (bus.in_valid && bus.in_ready)
      exp_q.push_back(model(int'(bus.a), int'(bus.b), int'(bus.delta), int'(bus.sqrt_delta)));
  end
  always @(negedge clk) if (rst_n) begin
    check("ready_valid_excl", int'(bus.in_ready && bus.out_valid), 0);
    if (bus.out_valid) begin
      if (exp_q.size() == 0) check("unexpected_result", 1, 0);
      else begin
        check("model_x1", int'(bus.x1), exp_q[0].x1);
        check("model_x2", int'(bus.x2), exp_q[0].x2);
        check("model_status", int'(bus.root_status), exp_q[0].st);
      end
    end
  end
  task automatic run_job(input int a, input int b, input int dl, input int s, input int x1,
                         input int x2, input int st, input int lat, input int hold, input bit intrude);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("idle_before_job", int'(bus.in_ready), 1);
    bus.a = 8'(a);
    bus.b = 8'(b);
    bus.delta = 16'(dl);
    bus.sqrt_delta = 8'(s);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("busy_after_capture", int'(bus.in_ready), 0);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (intrude) begin
        bus.in_valid = (n >= 3 && n < 6);
        bus.a = 8'd1;
        bus.b = 8'd2;
        bus.delta = 16'd0;
        bus.sqrt_delta = 8'd0;
        if (bus.in_valid) check("intrude_ready", int'(bus.in_ready), 0);
      end
    end
    check("latency", n, lat);
    check("lit_x1", int'(bus.x1), x1);
    check("lit_x2", int'(bus.x2), x2);
    check("lit_status", int'(bus.root_status), st);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", int'(bus.out_valid), 1);
      check("hold_x1", int'(bus.x1), x1);
      check("hold_x2", int'(bus.x2), x2);
      check("hold_status", int'(bus.root_status), st);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    if (!tie) bus.out_ready = 1'b0;
    check("ack_valid_low", int'(bus.out_valid), 0);
    check("ack_ready_high", int'(bus.in_ready), 1);
  endtask
  int jobs [12][9] = '{
    '{1, -5, 1, 1, 3, 2, 0, 19, 5},
    '{1, 2, 0, 0, -1, -1, 1, 19, 0},
    '{-1, 0, 16, 4, -2, 2, 0, 19, 1},
    '{2, -1, 25, 5, 1, -1, 0, 19, 0},
    '{-128, -128, 16384, 0, 0, 0, 3, 1, 2},
    '{1, 1, -7, 0, 0, 0, 2, 1, 0},
    '{0, 3, 9, 3, 0, 0, 3, 1, 0},
    '{1, -128, 324, 18, 73, 55, 0, 19, 0},
    '{1, 0, 325, 18, 0, 0, 3, 1, 0},
    '{-3, 7, 4, 2, 0, 1, 0, 19, 0},
    '{3, 7, 4, 2, 0, -1, 0, 19, 0},
    '{-128, 127, 1, 1, 0, 0, 0, 19, 0}
  };
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    exp_t e;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.delta = '0;
    bus.sqrt_delta = '0;
    e = model(1, -5, 1, 1);
    check("pin_a_x1", e.x1, 3);
    check("pin_a_x2", e.x2, 2);
    e = model(2, -1, 25, 5);
    check("pin_b_x1", e.x1, 1);
    check("pin_b_x2", e.x2, -1);
    e = model(-1, 0, 16, 4);
    check("pin_c_x1", e.x1, -2);
    check("pin_c_x2", e.x2, 2);
    e = model(0, 3, 9, 3);
    check("pin_d_st", e.st, 3);
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_x1", int'(bus.x1), 0);
    check("rst_x2", int'(bus.x2), 0);
    check("rst_status", int'(bus.root_status), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++)
      run_job(jobs[i][0], jobs[i][1], jobs[i][2], jobs[i][3], jobs[i][4],
              jobs[i][5], jobs[i][6], jobs[i][7], jobs[i][8], 1'b0);
    run_job(1, -5, 1, 1, 3, 2, 0, 19, 0, 1'b1);
    tie = 1'b1;
    bus.out_ready = 1'b1;
    run_job(-1, 0, 16, 4, -2, 2, 0, 19, 0, 1'b0);
    run_job(2, -1, 25, 5, 1, -1, 0, 19, 0, 1'b0);
    run_job(1, 1, -7, 0, 0, 0, 2, 1, 0, 1'b0);
    tie = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = 8'd1;
    bus.b = -8'sd5;
    bus.delta = 16'd1;
    bus.sqrt_delta = 8'd1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_x1", int'(bus.x1), 0);
    check("midrst_x2", int'(bus.x2), 0);
    check("midrst_status", int'(bus.root_status), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(1, 2, 0, 0, -1, -1, 1, 19, 2, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
